// File: rtl/rf_write_port_ctrl.sv
// rf_write_port_ctrl: write-side controller for the 32x32 register file.
// Buffers completed results (valid/ready) in an in-order FIFO, drains one entry
// per clock into the PW/RW/LE write port and exports a per-register BUSY map.
// Optional forwarding compare port is built only when RFWP_BYPASS_EN is defined.
//
// state  | meaning
// EMPTY  | COUNT == 0, nothing queued
// ACTIVE | 0 < COUNT < DEPTH
// FULL   | COUNT == DEPTH, IN_READY low
module rf_write_port_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [AW-1:0]           IN_RW,
    input  logic [DW-1:0]           IN_PW,
    input  logic                    HOLD,
    output logic [DW-1:0]           PW,
    output logic [AW-1:0]           RW,
    output logic                    LE,
    output logic [(1<<AW)-1:0]      BUSY,
    output logic [$clog2(DEPTH):0]  COUNT
`ifdef RFWP_BYPASS_EN
    ,
    input  logic [AW-1:0]           QA,
    output logic                    FWD_HIT,
    output logic [DW-1:0]           FWD_DATA
`endif
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        FULL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     ent_rw [DEPTH];
    logic [DW-1:0]     ent_pw [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTRW-1:0]   head;
    logic [PTRW-1:0]   tail;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    // R0 writes complete the handshake but are dropped; pops never bypass a same-cycle push.
    assign IN_READY = (count < FULL_CNT) && !RST;
    assign push     = IN_VALID && IN_READY && (IN_RW != '0);
    assign pop      = (count != '0) && !HOLD;
    assign COUNT    = count;

    // State register, kept in lockstep with count.
    always_ff @(posedge CLK) begin
        if (RST) state <= EMPTY;
        else     state <= state_next;
    end

    // Next-state from the push/pop decision of this cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:  if (push) state_next = ACTIVE;
            ACTIVE: begin
                if (pop && !push && count == CW'(1))       state_next = EMPTY;
                else if (push && !pop && count == LAST_CNT) state_next = FULL;
            end
            FULL:   if (pop) state_next = ACTIVE;
            default: state_next = EMPTY;
        endcase
    end

    // FIFO storage, pointers, occupancy and the registered write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            LE        <= 1'b0;
            RW        <= '0;
            PW        <= '0;
        end else begin
            if (pop) begin
                LE              <= 1'b1;
                RW              <= ent_rw[head];
                PW              <= ent_pw[head];
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end else begin
                LE <= 1'b0;
            end
            if (push) begin
                ent_rw[tail]    <= IN_RW;
                ent_pw[tail]    <= IN_PW;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pending-write map: queued entries plus the write currently on the port.
    always_comb begin
        BUSY = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) BUSY[ent_rw[i]] = 1'b1;
        end
        if (LE) BUSY[RW] = 1'b1;
        BUSY[0] = 1'b0;
    end

`ifdef RFWP_BYPASS_EN
    // Forwarding: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        logic [PTRW-1:0] idx;
        idx      = head;
        FWD_HIT  = 1'b0;
        FWD_DATA = '0;
        if (QA != '0) begin
            if (LE && RW == QA) begin
                FWD_HIT  = 1'b1;
                FWD_DATA = PW;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTRW'(i);
                if (ent_valid[idx] && ent_rw[idx] == QA) begin
                    FWD_HIT  = 1'b1;
                    FWD_DATA = ent_pw[idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Testbench for rf_write_port_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model. Covers forwarding when RFWP_BYPASS_EN is defined.
module tb_rf_write_port_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 1 << AW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [AW-1:0]  in_rw = '0;
    logic [DW-1:0]  in_pw = '0;
    logic           hold = 1'b0;
    logic [DW-1:0]  pw;
    logic [AW-1:0]  rw;
    logic           le;
    logic [NR-1:0]  busy;
    logic [2:0]     count;
`ifdef RFWP_BYPASS_EN
    logic [AW-1:0]  qa = '0;
    logic           fwd_hit;
    logic [DW-1:0]  fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [AW-1:0] m_rw_q[$];
    logic [DW-1:0] m_pw_q[$];
    logic          m_le = 1'b0;
    logic [AW-1:0] m_rw = '0;
    logic [DW-1:0] m_pw = '0;
    logic          exp_ready;
    logic          ready_seen;

    always #5 clk = ~clk;

    rf_write_port_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .CLK      (clk),
        .RST      (rst),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .IN_RW    (in_rw),
        .IN_PW    (in_pw),
        .HOLD     (hold),
        .PW       (pw),
        .RW       (rw),
        .LE       (le),
        .BUSY     (busy),
        .COUNT    (count)
`ifdef RFWP_BYPASS_EN
        ,
        .QA       (qa),
        .FWD_HIT  (fwd_hit),
        .FWD_DATA (fwd_data)
`endif
    );

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] b;
        b = '0;
        foreach (m_rw_q[i]) b[m_rw_q[i]] = 1'b1;
        if (m_le) b[m_rw] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    function automatic logic [2:0] model_count();
        return 3'(m_rw_q.size());
    endfunction

`ifdef RFWP_BYPASS_EN
    function automatic logic [DW:0] model_fwd(input logic [AW-1:0] q);
        if (q == '0) return '0;
        for (int i = m_rw_q.size() - 1; i >= 0; i--)
            if (m_rw_q[i] == q) return {1'b1, m_pw_q[i]};
        if (m_le && m_rw == q) return {1'b1, m_pw};
        return '0;
    endfunction
`endif

    // One clock: apply inputs, sample ready before the edge, advance the model, settle.
    task automatic step(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input logic h, input logic rs);
        in_valid = v;
        in_rw    = r;
        in_pw    = d;
        hold     = h;
        rst      = rs;
        #1;
        ready_seen = in_ready;
        exp_ready  = (m_rw_q.size() < DEPTH) && !rs;
        @(posedge clk);
        if (rs) begin
            m_rw_q.delete();
            m_pw_q.delete();
            m_le = 1'b0;
            m_rw = '0;
            m_pw = '0;
        end else begin
            if (m_rw_q.size() > 0 && !h) begin
                m_le = 1'b1;
                m_rw = m_rw_q.pop_front();
                m_pw = m_pw_q.pop_front();
            end else begin
                m_le = 1'b0;
            end
            if (v && exp_ready && r != '0) begin
                m_rw_q.push_back(r);
                m_pw_q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic idle(input logic h);
        step(1'b0, '0, '0, h, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(1'b0);
        total++;
        if ({le, rw, pw, count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got le=%0d rw=%0d pw=%0d count=%0d want all 0", le, rw, pw, count);
        end
        total++;
        if (busy !== '0) begin
            bad++;
            $display("FAIL reset_busy got=%h want=0", busy);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%0d want=1", in_ready);
        end
    endtask

    task automatic test_single_write();
        step(1'b1, 5'd3, 32'd20, 1'b0, 1'b0);
        total++;
        if ({ready_seen, le, count, busy[3]} !== {1'b1, 1'b0, 3'd1, 1'b1}) begin
            bad++;
            $display("FAIL single_accept got ready=%0d le=%0d count=%0d busy3=%0d want 1 0 1 1",
                     ready_seen, le, count, busy[3]);
        end
        idle(1'b0);
        total++;
        if ({le, rw, pw, count, busy[3]} !== {1'b1, 5'd3, 32'd20, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL single_issue got le=%0d rw=%0d pw=%0d count=%0d busy3=%0d want 1 3 20 0 1",
                     le, rw, pw, count, busy[3]);
        end
        idle(1'b0);
        total++;
        if ({le, busy} !== '0) begin
            bad++;
            $display("FAIL single_done got le=%0d busy=%h want 0 0", le, busy);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(20 + i), 1'b1, 1'b0);
        total++;
        if ({count, in_ready, le} !== {3'd4, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL full_state got count=%0d ready=%0d le=%0d want 4 0 0", count, in_ready, le);
        end
        step(1'b1, 5'd5, 32'd99, 1'b1, 1'b0);
        total++;
        if ({ready_seen, count, busy[5]} !== {1'b0, 3'd4, 1'b0}) begin
            bad++;
            $display("FAIL full_reject got ready=%0d count=%0d busy5=%0d want 0 4 0", ready_seen, count, busy[5]);
        end
        for (int i = 1; i <= 4; i++) begin
            idle(1'b0);
            total++;
            if ({le, rw, pw} !== {1'b1, AW'(i), DW'(20 + i)}) begin
                bad++;
                $display("FAIL drain_%0d got le=%0d rw=%0d pw=%0d want 1 %0d %0d", i, le, rw, pw, i, 20 + i);
            end
        end
        idle(1'b0);
        total++;
        if ({le, count} !== '0) begin
            bad++;
            $display("FAIL drain_end got le=%0d count=%0d want 0 0", le, count);
        end
    endtask

    task automatic test_r0_drop();
        step(1'b1, 5'd0, 32'd55, 1'b0, 1'b0);
        total++;
        if ({ready_seen, count} !== {1'b1, 3'd0}) begin
            bad++;
            $display("FAIL r0_accept got ready=%0d count=%0d want 1 0", ready_seen, count);
        end
        idle(1'b0);
        total++;
        if ({le, busy} !== '0) begin
            bad++;
            $display("FAIL r0_nowrite got le=%0d busy=%h want 0 0", le, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] seen[$];
        int            max_cnt;
        logic [NR-1:0] b7;
        max_cnt = 0;
        b7      = '0;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: step(1'b1, 5'd7, 32'd10, 1'b0, 1'b0);
                1: step(1'b1, 5'd7, 32'd11, 1'b0, 1'b0);
                2: step(1'b1, 5'd9, 32'd12, 1'b0, 1'b0);
                default: idle(1'b0);
            endcase
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (le === 1'b1) seen.push_back(pw);
            b7[c] = busy[7];
        end
        total++;
        if (max_cnt > 2) begin
            bad++;
            $display("FAIL b2b_max_count got=%0d want<=2", max_cnt);
        end
        total++;
        if (seen.size() != 3 || seen[0] !== 32'd10 || seen[1] !== 32'd11 || seen[2] !== 32'd12) begin
            bad++;
            $display("FAIL b2b_order got n=%0d want 10,11,12", seen.size());
        end
        // busy[7] high through the cycle where PW=11 issues, low once 12 is on the port
        total++;
        if (b7[5:0] !== 6'b000111) begin
            bad++;
            $display("FAIL b2b_busy7 got=%b want=000111", b7[5:0]);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3; i++) step(1'b1, AW'(2 + 2 * i), DW'(30 + i), 1'b1, 1'b0);
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL rstmid_fill got count=%0d want 3", count);
        end
        step(1'b0, '0, '0, 1'b1, 1'b1);
        total++;
        if ({count, busy, le} !== '0) begin
            bad++;
            $display("FAIL rstmid_clear got count=%0d busy=%h le=%0d want 0", count, busy, le);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            if (le === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rstmid_noissue got pulses=%0d want 0", pulses);
        end
    endtask

`ifdef RFWP_BYPASS_EN
    task automatic test_bypass();
        step(1'b1, 5'd7, 32'd10, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'd11, 1'b1, 1'b0);
        qa = 5'd7;
        #1;
        total++;
        if ({fwd_hit, fwd_data} !== {1'b1, 32'd11}) begin
            bad++;
            $display("FAIL bypass_youngest got hit=%0d data=%0d want 1 11", fwd_hit, fwd_data);
        end
        qa = 5'd3;
        #1;
        total++;
        if ({fwd_hit, fwd_data} !== '0) begin
            bad++;
            $display("FAIL bypass_miss got hit=%0d data=%0d want 0 0", fwd_hit, fwd_data);
        end
        qa = 5'd7;
        idle(1'b0);
        idle(1'b0);
        total++;
        if ({le, fwd_hit, fwd_data} !== {1'b1, 1'b1, 32'd11}) begin
            bad++;
            $display("FAIL bypass_outstage got le=%0d hit=%0d data=%0d want 1 1 11", le, fwd_hit, fwd_data);
        end
        idle(1'b0);
        total++;
        if (fwd_hit !== 1'b0) begin
            bad++;
            $display("FAIL bypass_clear got hit=%0d want 0", fwd_hit);
        end
        qa = '0;
    endtask
`endif

    task automatic test_random();
        logic          v;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic          h;
        logic          rs;
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 9) < 6);
            r  = AW'($urandom_range(0, 7));
            d  = $urandom;
            h  = ($urandom_range(0, 9) < 3);
            rs = ($urandom_range(0, 99) == 0);
            step(v, r, d, h, rs);
            total++;
            if (ready_seen !== exp_ready) begin
                bad++;
                $display("FAIL rand_ready n=%0d got=%0d want=%0d", n, ready_seen, exp_ready);
            end
            total++;
            if ({le, rw, pw, count} !== {m_le, m_rw, m_pw, model_count()}) begin
                bad++;
                $display("FAIL rand_port n=%0d got le=%0d rw=%0d pw=%h cnt=%0d want le=%0d rw=%0d pw=%h cnt=%0d",
                         n, le, rw, pw, count, m_le, m_rw, m_pw, model_count());
            end
            total++;
            if (busy !== model_busy()) begin
                bad++;
                $display("FAIL rand_busy n=%0d got=%h want=%h", n, busy, model_busy());
            end
`ifdef RFWP_BYPASS_EN
            qa = AW'($urandom_range(0, 7));
            #1;
            total++;
            if ({fwd_hit, fwd_data} !== model_fwd(qa)) begin
                bad++;
                $display("FAIL rand_fwd n=%0d qa=%0d got hit=%0d data=%h want=%h",
                         n, qa, fwd_hit, fwd_data, model_fwd(qa));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_full();
        test_r0_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef RFWP_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_write_port_ctrl.md
Name: rf_write_port_ctrl

Overview:
- Write-side controller for the 32x32 register file: the producer end of the PW/RW/LE write port.
- Accepts completed results from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per clock into the register file write port.
- Exports a per-register BUSY scoreboard so the decode stage can stall on pending writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..8
- DW, 32, data width of PW
- AW, 5, register address width; 2^AW registers

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous active-high reset, sampled on the CLK rising edge
- IN_VALID  input  1  producer has a result
- IN_READY  output  1  block can accept; transfer occurs when IN_VALID & IN_READY at the edge
- IN_RW  input  AW  destination register of the result
- IN_PW  input  DW  result data
- HOLD  input  1  drain stall; no pop while high
- PW  output  DW  register file write data
- RW  output  AW  register file write address
- LE  output  1  register file load enable; a one-cycle pulse per write
- BUSY  output  2^AW  bit r = write to r still pending
- COUNT  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values, applied on the edge where RST=1: COUNT=0, LE=0, RW=0, PW=0, state=EMPTY, all FIFO entries invalid, BUSY=0 from the next cycle. Reset mid-operation discards queued entries; they never reach the register file.
- IN_READY = (COUNT < DEPTH) and not RST. This is combinational on state only, never on IN_VALID. Full means not ready, even if a pop occurs in the same cycle.
- R0 is hardwired zero. An accepted transfer with IN_RW=0 completes the handshake but is not enqueued, and COUNT is unchanged.
- Push: on an accepted transfer with IN_RW≠0, write {IN_RW, IN_PW} at the tail, advance the tail pointer, COUNT+1.
- Pop: at an edge where COUNT>0 and HOLD=0, take the head entry:
  - LE<=1, RW<=head.rw, PW<=head.pw
  - advance the head pointer, COUNT-1
  - otherwise LE<=0, and RW/PW hold their last values.
- Simultaneous push and pop: COUNT unchanged, both pointers advance. A push into an empty FIFO is not bypassed: the entry pops at the next edge at the earliest.
- Latency: transfer accepted at edge N → LE=1 after edge N+1 → register file updated at edge N+2, with HOLD low throughout.
- Ordering: strictly in arrival order. Two writes to the same register land in acceptance order, so the last accepted value wins.
- Pointers wrap modulo DEPTH.
- State machine, registered and updated alongside COUNT:
  - EMPTY (COUNT=0): push → ACTIVE.
  - ACTIVE (0<COUNT<DEPTH): pop without push at COUNT=1 → EMPTY; push without pop at COUNT=DEPTH-1 → FULL.
  - FULL (COUNT=DEPTH): pop → ACTIVE; a push is impossible in this state.
  - The state and COUNT must agree every cycle.
- BUSY[r]=1 when:
  - any valid FIFO entry has rw=r, or
  - LE=1 and RW=r (the write issued but not yet landed).
- BUSY is combinational from registered state, and BUSY[0] is always 0.
- HOLD high freezes the FIFO contents and forces LE low, while pushes continue until FULL.

Optional Feature:
- Macro: RFWP_BYPASS_EN.
- Defined: adds ports QA input AW, FWD_HIT output 1 and FWD_DATA output DW, all combinational.
  - FWD_HIT=1 when QA≠0 and QA matches a pending write: any valid FIFO entry, or the output stage with LE=1.
  - FWD_DATA is the youngest matching value; the tail side has priority over the output stage.
  - On no hit, FWD_DATA=0.
- Undefined: those ports do not exist and no compare logic is built; all other behaviour is identical.

Test Plan:
- Reset/idle: RST high for 2 cycles, then IN_VALID=0 → LE=0, RW=0, PW=0, COUNT=0, BUSY=0, IN_READY=1.
- Single write: push RW=3, PW=20 at edge N → at N+1: LE=1, RW=3, PW=20; BUSY[3]=1 from after N through the N+1 cycle, 0 after N+2; COUNT returns to 0.
- Fill/full:
  - HOLD=1, push RW=1..4 with PW=21..24 → COUNT=4, state FULL, IN_READY=0; a 5th push (RW=5) is not accepted.
  - Release HOLD → four LE pulses on consecutive cycles with RW 1,2,3,4 and PW 21..24.
- R0 drop: push RW=0, PW=55 → handshake completes, COUNT stays 0, no LE pulse, BUSY[0]=0.
- Same-register ordering plus simultaneous push/pop: stream pushes (RW=7, PW=10), (RW=7, PW=11), (RW=9, PW=12) back-to-back while draining → COUNT never exceeds 2, LE order 10, 11, 12, BUSY[7] clears only after the PW=11 write issues.
- Reset mid-operation: COUNT=3 with HOLD=1, assert RST one cycle → COUNT=0, BUSY=0, no LE for the discarded entries.
- With RFWP_BYPASS_EN defined: same pending pair on RW=7 and QA=7 → FWD_HIT=1, FWD_DATA=11.
